// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and FSM state type for the memory responder
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int MAX_WAIT   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port synchronous RAM with registered read port
module ram_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Only the read register is reset; it feeds the datapath, the array is left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder with four-phase done handshake
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              done,
  output logic              busy,
  output logic              err
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("WAIT_STATES out of range");
  end

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  state_t              state;
  logic [2:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_write;
  logic                access;

  // The RAM is strobed in the last WAIT cycle so its read register lands with done.
  assign access = (state == WAIT) && (cnt == 3'd0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Read && Write) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b1;
          end else if (Read || Write) begin
            state    <= WAIT;
            cnt      <= WAIT_LOAD;
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= Write;
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            state <= RESP;
            done  <= 1'b1;
          end
        end
        RESP, ERR: begin
          if (!Read && !Write) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(clr),
    .en   (access),
    .we   (op_write),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(Mdatain)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - four responders (WAIT_STATES 1,0,3,7) on shared request lines
module tb_mem_responder;

  localparam int N = 4;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] mdata  [N];
  logic        done_o [N];
  logic        busy_o [N];
  logic        err_o  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.WAIT_STATES(ws_of(g))) dut (
      .clk    (clk),
      .clr    (clr),
      .Read   (rd),
      .Write  (wr),
      .addr   (addr),
      .wdata  (wdata),
      .Mdatain(mdata[g]),
      .done   (done_o[g]),
      .busy   (busy_o[g]),
      .err    (err_o[g])
    );
  end

  int unsigned checks = 0;
  int unsigned fails  = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ws=%0d t=%0t got %h expected %h", name, ws_of(i), $time, act, exp);
    end
  endtask

  // Model: each responder is either idle, holding an accepted access, or holding a conflict.
  // Completion edge = acceptance edge + WAIT_STATES + 1.
  int          edge_n = 0;
  int          kind  [N];
  int          t_acc [N];
  bit          m_w   [N];
  logic [8:0]  m_a   [N];
  logic [31:0] m_d   [N];
  logic [31:0] exp_q [N];
  bit          known [N];
  logic [31:0] mem_m [int];

  initial begin
    for (int i = 0; i < N; i++) begin
      kind[i] = 0; t_acc[i] = 0; exp_q[i] = '0; known[i] = 1'b1;
    end
  end

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < N; i++) begin
        kind[i] = 0; exp_q[i] = '0; known[i] = 1'b1;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < N; i++) begin
        if (kind[i] == 0) begin
          if (rd && wr) begin
            kind[i] = 2; t_acc[i] = edge_n;
          end else if (rd || wr) begin
            kind[i] = 1; t_acc[i] = edge_n;
            m_w[i] = wr; m_a[i] = addr; m_d[i] = wdata;
          end
        end else if (kind[i] == 1) begin
          if (edge_n == t_acc[i] + ws_of(i) + 1) begin
            if (m_w[i]) mem_m[i*1024 + int'(m_a[i])] = m_d[i];
            else if (mem_m.exists(i*1024 + int'(m_a[i]))) begin
              exp_q[i] = mem_m[i*1024 + int'(m_a[i])]; known[i] = 1'b1;
            end else known[i] = 1'b0;
          end else if (edge_n > t_acc[i] + ws_of(i) + 1 && !rd && !wr) begin
            kind[i] = 0;
          end
        end else if (!rd && !wr) begin
          kind[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      chk("busy", i, 32'(busy_o[i]), 32'(kind[i] != 0));
      chk("done", i, 32'(done_o[i]), 32'(kind[i] == 1 && edge_n >= t_acc[i] + ws_of(i) + 1));
      chk("err", i, 32'(err_o[i]), 32'(kind[i] == 2));
      if (known[i]) chk("Mdatain", i, mdata[i], exp_q[i]);
    end
  end

  int lat [N];

  task automatic access(input bit r, input bit w, input logic [8:0] a, input logic [31:0] d, input int hold);
    int  n;
    bit  all;
    for (int i = 0; i < N; i++) lat[i] = -1;
    rd = r; wr = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        addr = ~a; wdata = ~d;
      end
      all = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (done_o[i] && lat[i] < 0) lat[i] = n - 1;
        if (!(done_o[i] || err_o[i])) all = 1'b0;
      end
    end while (!all && n < 20);
    if (!all) begin
      checks++; fails++;
      $display("FAIL handshake_timeout addr=%h got no done/err within 20 cycles", a);
    end
    addr = 9'h010; wdata = '0;
    repeat (hold) @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_lat();
    for (int i = 0; i < N; i++) chk("latency", i, 32'(lat[i]), 32'(ws_of(i) + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      chk("reset_Mdatain", i, mdata[i], 32'h0);
      chk("reset_done", i, 32'(done_o[i]), 32'h0);
      chk("reset_busy", i, 32'(busy_o[i]), 32'h0);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    access(1'b0, 1'b1, 9'h010, 32'h0000_0000, 0);
    access(1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, 0);
    chk_lat();
    access(1'b1, 1'b0, 9'h005, 32'h0, 0);
    chk_lat();
    for (int i = 0; i < N; i++) chk("read_DEADBEEF", i, mdata[i], 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 9'h005, 32'h0, 5);
    for (int i = 0; i < N; i++) begin
      chk("hold_no_reaccess", i, mdata[i], 32'hDEAD_BEEF);
      chk("hold_released", i, 32'(done_o[i]), 32'h0);
    end

    rd = 1'b1; wr = 1'b1; addr = 9'h005; wdata = 32'h0000_0BAD;
    @(negedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      chk("conflict_err", i, 32'(err_o[i]), 32'h1);
      chk("conflict_done", i, 32'(done_o[i]), 32'h0);
    end
    repeat (2) @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) chk("conflict_cleared", i, 32'(err_o[i]), 32'h0);
    access(1'b1, 1'b0, 9'h005, 32'h0, 0);
    for (int i = 0; i < N; i++) chk("conflict_mem_kept", i, mdata[i], 32'hDEAD_BEEF);

    rd = 1'b0; wr = 1'b1; addr = 9'h010; wdata = 32'h1234_5678;
    @(negedge clk);
    clr = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 9'h005, 32'h0, 0);
    access(1'b1, 1'b0, 9'h010, 32'h0, 0);
    for (int i = 0; i < N; i++) chk("reset_drops_write", i, mdata[i], 32'h0);

    access(1'b0, 1'b1, 9'h1FF, 32'hA5A5_5A5A, 1);
    access(1'b1, 1'b0, 9'h1FF, 32'h0, 0);
    chk_lat();
    for (int i = 0; i < N; i++) chk("read_top_addr", i, mdata[i], 32'hA5A5_5A5A);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU datapath's memory interface. It accepts read/write requests driven from the datapath's MAR (address) and MDR (write data) under the `Read`/`Write` strobes, performs the access on a 512×32 synchronous RAM after a configurable number of wait states, and returns read data on `Mdatain` (the datapath's MDR input). Completion is signalled with a four-phase `done` handshake, so the control sequencer can stall until memory finishes.

## Interface
- `ADDR_W`, 9: word address width; depth = 2**ADDR_W.
- `DATA_W`, 32: data word width.
- `WAIT_STATES`, 1: extra cycles between request acceptance and access, legal range 0..7.

- `clk`  in  1  system clock, all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `Read`  in  1  read request level, held high by the requester until `done` is seen.
- `Write`  in  1  write request level, same rules as `Read`.
- `addr`  in  ADDR_W  word address, driven from MAR[ADDR_W-1:0].
- `wdata`  in  DATA_W  write data, driven from the MDR output.
- `Mdatain`  out  DATA_W  registered read data, feeds the datapath's MDR input.
- `done`  out  1  access complete; held high until both requests are low.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  `Read` and `Write` both high in IDLE; held until both are low.

## Operation
- States: IDLE, WAIT, RESP, ERR.
- IDLE:
  - Exactly one of `Read`/`Write` high at an edge: latch `addr`, `wdata` and the operation, load `cnt`=WAIT_STATES, go to WAIT.
  - Both high: go to ERR. No access is made.
  - Neither high: stay in IDLE.
- WAIT, `cnt`>0: decrement `cnt`.
- WAIT, `cnt`==0: perform the access using the latched values, then go to RESP.
  - Read: `Mdatain` <= mem[addr_latched].
  - Write: mem[addr_latched] <= wdata_latched. `Mdatain` is unchanged.
- RESP: `done`=1. When `Read` and `Write` are both low, go to IDLE. Request inputs are ignored for the new access while in this state.
- ERR: `err`=1. When `Read` and `Write` are both low, go to IDLE.
- Input changes after acceptance (addr, wdata, strobes) have no effect until the state returns to IDLE.
- Address wrap: none possible, because the address is exactly ADDR_W bits.
- A request dropped early (during WAIT) does not abort the access. The access completes, then RESP exits on the first cycle both strobes are low.

## Timing
- Request is sampled at edge t. `done` rises after edge t+WAIT_STATES+1, and `Mdatain` is valid in the same cycle.
  - WAIT_STATES=0: `done` after edge t+1.
  - WAIT_STATES=1 (default): `done` after edge t+2.
- `done` falls after the first edge at which both strobes are low. The earliest next acceptance is the following edge, giving a minimum of 2 idle cycles between accesses at the requester.
- `busy` rises after edge t and falls together with `done`/`err`.
- Reset (`clr`=0, at any time, including mid-WAIT):
  - Immediately: state=IDLE, `cnt`=0, `Mdatain`=0, `done`=0, `busy`=0, `err`=0.
  - A write pending in WAIT is dropped and not committed.
  - RAM contents are not cleared by reset.
- Outputs are all registered. No combinational path exists from inputs to outputs.

## Structure
- Package `mem_pkg`:
  - state enum (IDLE, WAIT, RESP, ERR);
  - `MEM_ADDR_W`=9 and `MEM_DATA_W`=32 constants;
  - `MAX_WAIT`=7.
- Sub-module `ram_array`: single-port synchronous RAM, DEPTH×DATA_W, with write enable, 1-cycle registered read. The responder issues the access in the WAIT `cnt`==0 cycle, so the RAM's read register drives `Mdatain` directly. No reset on the array.
- Top level: the FSM, the 3-bit `cnt`, and the address/data/operation latches.

## Test plan
- Reset: hold `clr`=0 mid-sequence -> `Mdatain`=0, `done`=`busy`=`err`=0. After release, a new request is accepted normally.
- Write then read: Write addr=9'h05 wdata=32'hDEADBEEF, drop after `done`; then Read addr=9'h05 -> `Mdatain`=32'hDEADBEEF with `done` after edge t+2 (WAIT_STATES=1).
- Latency sweep: WAIT_STATES=0, 3, 7 -> `done` asserts after edge t+1, t+4, t+8 respectively.
- Handshake hold: keep `Read` high 5 cycles after `done` -> `done` stays high, no second access. Strobes low -> IDLE one edge later.
- Conflict: `Read`=`Write`=1 in IDLE -> `err`=1, `done`=0, memory at the address unchanged. Both low -> `err`=0.
- Reset mid-write: Write addr=9'h10 wdata=32'h12345678 with WAIT_STATES=3, assert `clr` during WAIT -> a later read of 9'h10 returns its prior value (32'h0 if never written after preload).
